// File: rtl/max6675_spi_reader.sv
// SPI poller for a MAX6675 thermocouple converter: frames cs_n/sclk, shifts in the 16-bit SO word,
// and publishes raw frame, temperature and open-TC flag. Optional MAX6675_FRAME_CHECK_EN rejects bad frames.
module max6675_spi_reader #(
   parameter int CLK_DIV     = 4,
   parameter int CONV_CYCLES = 22000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        so,
   output logic        cs_n,
   output logic        sclk,
   output logic [15:0] frame,
   output logic [11:0] temp_raw,
   output logic        open_tc,
   output logic        frame_valid,
   output logic        busy,
   output logic        frame_err
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int CW = $clog2(CONV_CYCLES + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_CONV,
      IDLE,
      CS_SETUP,
      SHIFT_LO,
      SHIFT_HI,
      CS_HOLD
   } state_t;

   state_t         state, state_n;
   logic [1:0]     so_sync;
   logic           so_s;
   logic [DW-1:0]  div_cnt;
   logic [CW-1:0]  conv_cnt;
   logic [3:0]     bit_cnt;
   logic [15:0]    shreg;
   logic           div_done;
   logic           shift_en;
   logic           frame_done;
   logic           start;
   logic           accept;

   assign so_s     = so_sync[1];
   assign div_done = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= WAIT_CONV;
      else        state <= state_n;
   end

   always_comb begin
      state_n    = state;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      start      = 1'b0;
      case (state)
         WAIT_CONV: if (conv_cnt == CONV_LAST) state_n = IDLE;
         IDLE: begin
            if (en) begin
               state_n = CS_SETUP;
               start   = 1'b1;
            end
         end
         CS_SETUP: if (div_done) state_n = SHIFT_LO;
         SHIFT_LO: if (div_done) state_n = SHIFT_HI;
         SHIFT_HI: begin
            if (div_done) begin
               shift_en = 1'b1;
               state_n  = (bit_cnt == 4'd15) ? CS_HOLD : SHIFT_LO;
            end
         end
         CS_HOLD: begin
            if (div_done) begin
               frame_done = 1'b1;
               state_n    = WAIT_CONV;
            end
         end
         default: state_n = WAIT_CONV;
      endcase
   end

`ifdef MAX6675_FRAME_CHECK_EN
   // D15 is a dummy sign bit and D1 the device ID; both read 0 on a healthy bus.
   assign accept = ~shreg[15] & ~shreg[1];

   always_ff @(posedge clk) begin
      if (!rst_n)          frame_err <= 1'b0;
      else if (frame_done) frame_err <= ~accept;
   end
`else
   assign accept    = 1'b1;
   assign frame_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         so_sync     <= '0;
         div_cnt     <= '0;
         conv_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         cs_n        <= 1'b1;
         sclk        <= 1'b0;
         busy        <= 1'b1;
         frame       <= '0;
         temp_raw    <= '0;
         open_tc     <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         so_sync <= {so_sync[0], so};

         // Both counters restart on every state entry, so neither can wrap.
         if (state_n != state) begin
            div_cnt  <= '0;
            conv_cnt <= '0;
         end else if (state == WAIT_CONV) begin
            conv_cnt <= conv_cnt + 1'b1;
         end else if (state != IDLE) begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (start)                             bit_cnt <= '0;
         else if (shift_en && bit_cnt != 4'd15) bit_cnt <= bit_cnt + 1'b1;

         if (shift_en) shreg <= {shreg[14:0], so_s};

         // Pins follow the next state so they change on the transition edge.
         cs_n        <= !(state_n inside {CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD});
         sclk        <= (state_n == SHIFT_HI);
         busy        <= (state_n != IDLE);
         frame_valid <= frame_done;

         if (frame_done) begin
            frame <= shreg;
            if (accept) begin
               open_tc <= shreg[2];
               if (!shreg[2]) temp_raw <= shreg[14:3];
            end
         end
      end
   end

endmodule
